// File: rtl/sdes_pkg.sv
// ---------------------------------------------------------------------------
// sdes_pkg
// Shared S-DES definitions for the decryption engine: fixed widths, the
// engine state encoding and the bit permutations used by the key schedule
// and the data path. Every vector is indexed [0:N-1], so bit 0 is the
// leftmost bit, which matches the 1-based permutation tables directly
// (table entry n selects bit n-1).
// ---------------------------------------------------------------------------
package sdes_pkg;

   localparam int BLK_W  = 8;
   localparam int KEY_W  = 10;
   localparam int HALF_W = 4;

   typedef logic [0:BLK_W-1]  blk_t;
   typedef logic [0:KEY_W-1]  key_t;
   typedef logic [0:HALF_W-1] half_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYGEN = 3'd1,
      R1     = 3'd2,
      R2     = 3'd3,
      DONE   = 3'd4
   } state_t;

   // P10 = 3 5 2 7 4 10 1 9 8 6
   function automatic key_t p10(input key_t k);
      return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
   endfunction

   // P8 = 6 3 7 4 8 5 10 9 (bits 1 and 2 are dropped)
   function automatic blk_t p8(input key_t k);
      return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
   endfunction

   // Rotate each 5-bit half left by one, independently
   function automatic key_t ls1(input key_t k);
      return {k[1:4], k[0], k[6:9], k[5]};
   endfunction

   // Rotate each 5-bit half left by two, independently
   function automatic key_t ls2(input key_t k);
      return {k[2:4], k[0:1], k[7:9], k[5:6]};
   endfunction

   // IP = 2 6 3 1 4 8 5 7
   function automatic blk_t ip(input blk_t d);
      return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
   endfunction

   // IP^-1 = 4 1 3 5 7 2 8 6
   function automatic blk_t ip_inv(input blk_t d);
      return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
   endfunction

   // Swap the two 4-bit halves
   function automatic blk_t sw(input blk_t d);
      return {d[4:7], d[0:3]};
   endfunction

endpackage

// File: rtl/sdes_fk.sv
// ---------------------------------------------------------------------------
// sdes_fk
// Combinational S-DES Feistel round fk(L,R,K) = (L xor P4(S(EP(R) xor K)), R).
// Ports:
//   din    in  [0:7]  {L,R} round input
//   subkey in  [0:7]  round subkey
//   dout   out [0:7]  {L xor f, R}; no swap is applied here
// ---------------------------------------------------------------------------
module sdes_fk
   import sdes_pkg::*;
(
   input  logic [0:BLK_W-1] din,
   input  logic [0:BLK_W-1] subkey,
   output logic [0:BLK_W-1] dout
);

   // S0: row = {b1,b4}, column = {b2,b3}
   function automatic logic [0:1] sbox0(input logic [0:3] x);
      logic [0:1] s;
      case ({x[0], x[3], x[1], x[2]})
         4'd0:  s = 2'd1;
         4'd1:  s = 2'd0;
         4'd2:  s = 2'd3;
         4'd3:  s = 2'd2;
         4'd4:  s = 2'd3;
         4'd5:  s = 2'd2;
         4'd6:  s = 2'd1;
         4'd7:  s = 2'd0;
         4'd8:  s = 2'd0;
         4'd9:  s = 2'd2;
         4'd10: s = 2'd1;
         4'd11: s = 2'd3;
         4'd12: s = 2'd3;
         4'd13: s = 2'd1;
         4'd14: s = 2'd3;
         4'd15: s = 2'd2;
         default: s = 2'd0;
      endcase
      return s;
   endfunction

   // S1: row = {b1,b4}, column = {b2,b3}
   function automatic logic [0:1] sbox1(input logic [0:3] x);
      logic [0:1] s;
      case ({x[0], x[3], x[1], x[2]})
         4'd0:  s = 2'd0;
         4'd1:  s = 2'd1;
         4'd2:  s = 2'd2;
         4'd3:  s = 2'd3;
         4'd4:  s = 2'd2;
         4'd5:  s = 2'd0;
         4'd6:  s = 2'd1;
         4'd7:  s = 2'd3;
         4'd8:  s = 2'd3;
         4'd9:  s = 2'd0;
         4'd10: s = 2'd1;
         4'd11: s = 2'd0;
         4'd12: s = 2'd2;
         4'd13: s = 2'd1;
         4'd14: s = 2'd0;
         4'd15: s = 2'd3;
         default: s = 2'd0;
      endcase
      return s;
   endfunction

   logic [0:BLK_W-1]  ep_s;
   logic [0:BLK_W-1]  x_s;
   logic [0:HALF_W-1] s_s;
   logic [0:HALF_W-1] p4_s;

   // EP = 4 1 2 3 2 3 4 1 applied to R = din[4:7]
   assign ep_s = {din[7], din[4], din[5], din[6], din[5], din[6], din[7], din[4]};
   assign x_s  = ep_s ^ subkey;
   assign s_s  = {sbox0(x_s[0:3]), sbox1(x_s[4:7])};
   // P4 = 2 4 3 1
   assign p4_s = {s_s[1], s_s[3], s_s[2], s_s[0]};
   assign dout = {din[0:3] ^ p4_s, din[4:7]};

endmodule

// File: rtl/sdes_decrypt.sv
// ---------------------------------------------------------------------------
// sdes_decrypt
// Iterative S-DES decryption engine, one Feistel round per clock:
// IP, fk(K2), SW, fk(K1), IP^-1. One block in flight.
// Optional build macro SDES_KEY_CACHE_EN: when the accepted key matches the
// key whose subkeys are already held, KEYGEN is skipped (latency 2 instead
// of 3 edges).
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   ct/key valid
//   in_ready  out  engine idle and able to accept (registered)
//   ct        in   [0:7] ciphertext, bit 0 leftmost
//   key       in   [0:9] master key, bit 0 leftmost
//   out_valid out  pt valid (registered)
//   out_ready in   consumer accepts pt
//   pt        out  [0:7] plaintext (registered, held until the next result)
// ---------------------------------------------------------------------------
module sdes_decrypt
   import sdes_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:BLK_W-1] ct,
   input  logic [0:KEY_W-1] key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:BLK_W-1] pt
);

   state_t state_r;
   key_t   key_r;
   blk_t   data_r;
   blk_t   k1_r;
   blk_t   k2_r;
   blk_t   pt_r;
   logic   out_valid_r;
   logic   in_ready_r;
`ifdef SDES_KEY_CACHE_EN
   logic   key_cached_r;
`endif

   blk_t   sub_key_s;
   blk_t   fk_out_s;

   // Single shared round: decryption uses K2 first, then K1
   always_comb begin
      sub_key_s = k1_r;
      case (state_r)
         R1:      sub_key_s = k2_r;
         R2:      sub_key_s = k1_r;
         default: sub_key_s = k1_r;
      endcase
   end

   sdes_fk u_fk (
      .din    (data_r),
      .subkey (sub_key_s),
      .dout   (fk_out_s)
   );

   // Engine FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         key_r        <= '0;
         data_r       <= '0;
         k1_r         <= '0;
         k2_r         <= '0;
         pt_r         <= '0;
         out_valid_r  <= 1'b0;
         in_ready_r   <= 1'b0;
`ifdef SDES_KEY_CACHE_EN
         key_cached_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  data_r     <= ip(ct);
                  key_r      <= key;
                  in_ready_r <= 1'b0;
`ifdef SDES_KEY_CACHE_EN
                  // Subkeys already held for this key: go straight to round 1
                  if (key_cached_r && (key == key_r)) begin
                     state_r <= R1;
                  end else begin
                     state_r <= KEYGEN;
                  end
`else
                  state_r <= KEYGEN;
`endif
               end else begin
                  // First edge after reset release raises in_ready here
                  in_ready_r <= 1'b1;
               end
            end
            KEYGEN: begin
               k1_r    <= p8(ls1(p10(key_r)));
               k2_r    <= p8(ls2(ls1(p10(key_r))));
               state_r <= R1;
`ifdef SDES_KEY_CACHE_EN
               key_cached_r <= 1'b1;
`endif
            end
            R1: begin
               data_r  <= sw(fk_out_s);
               state_r <= R2;
            end
            R2: begin
               pt_r        <= ip_inv(fk_out_s);
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign pt        = pt_r;

endmodule

// File: tb/tb_sdes_decrypt.sv
// ---------------------------------------------------------------------------
// tb_sdes_decrypt
// Directed and model-based bench for sdes_decrypt. Honours SDES_KEY_CACHE_EN
// for the expected latencies.
// ---------------------------------------------------------------------------
module tb_sdes_decrypt;
   import sdes_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [0:7] ct;
   logic [0:9] key;
   logic       out_valid;
   logic       out_ready;
   logic [0:7] pt;

   int n_checks = 0;
   int n_errors = 0;

   bit         cache_vld = 1'b0;
   logic [9:0] cache_key = 10'd0;

   localparam logic [9:0] STD_KEY = 10'b1010000010;
   localparam logic [7:0] STD_CT  = 8'b00111000;
   localparam logic [7:0] STD_PT  = 8'b10010111;

   int s0_t [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   int s1_t [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   always #5 clk = ~clk;

   sdes_decrypt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt)
   );

   // ---------------- software S-DES model (tables as nibble lists) --------
   function automatic logic [9:0] perm(input logic [9:0] v, input int n_in,
                                       input logic [39:0] tbl, input int n_out);
      logic [9:0] r;
      int idx;
      r = 10'd0;
      for (int i = 0; i < n_out; i++) begin
         idx = int'(tbl[(n_out-1-i)*4 +: 4]);
         r[n_out-1-i] = v[n_in-idx];
      end
      return r;
   endfunction

   function automatic logic [9:0] rot_halves(input logic [9:0] v, input int n);
      logic [9:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[8:5], r[9], r[3:0], r[4]};
      return r;
   endfunction

   function automatic logic [7:0] m_fk(input logic [7:0] d, input logic [7:0] k);
      logic [7:0] e;
      logic [3:0] s;
      int a, b;
      e = perm({6'd0, d[3:0]}, 4, 40'h00_4123_2341, 8) ^ k;
      a = s0_t[int'({e[7], e[4]}) * 4 + int'({e[6], e[5]})];
      b = s1_t[int'({e[3], e[0]}) * 4 + int'({e[2], e[1]})];
      s = {a[1:0], b[1:0]};
      s = perm({6'd0, s}, 4, 40'h00_0000_2431, 4);
      return {d[7:4] ^ s, d[3:0]};
   endfunction

   function automatic logic [7:0] m_decrypt(input logic [9:0] k, input logic [7:0] c);
      logic [9:0] t, a, b;
      logic [7:0] k1, k2, d;
      t  = perm(k, 10, 40'h3527_4A19_86, 10);
      a  = rot_halves(t, 1);
      b  = rot_halves(t, 3);
      k1 = perm(a, 10, 40'h00_6374_85A9, 8);
      k2 = perm(b, 10, 40'h00_6374_85A9, 8);
      d  = perm({2'd0, c}, 8, 40'h00_2631_4857, 8);
      d  = m_fk(d, k2);
      d  = {d[3:0], d[7:4]};
      d  = m_fk(d, k1);
      return perm({2'd0, d}, 8, 40'h00_4135_7286, 8);
   endfunction

   // Stimulus: offer one block, alter ct/key after acceptance, report latency
   task automatic run_block(input logic [9:0] k, input logic [7:0] c,
                            output int lat, output int exp_lat, output logic [7:0] got);
      int waits;
      exp_lat = 3;
`ifdef SDES_KEY_CACHE_EN
      if (cache_vld && cache_key == k) exp_lat = 2;
`endif
      cache_vld = 1'b1;
      cache_key = k;
      key = k;
      ct = c;
      in_valid = 1'b1;
      waits = 0;
      while (!in_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      ct = ~ct;
      key = ~key;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      if (!out_valid) lat = 99;
      got = pt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      ct = 8'd0;
      key = 10'd0;
      cache_vld = 1'b0;
      #12;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || pt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_hold: in_ready=%b out_valid=%b pt=%b want 0 0 00000000", in_ready, out_valid, pt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_standard();
      int lat, el;
      logic [7:0] got;
      out_ready = 1'b1;
      run_block(STD_KEY, STD_CT, lat, el, got);
      n_checks++;
      if (lat != 3) begin
         n_errors++;
         $display("FAIL std_latency: got %0d want 3", lat);
      end
      n_checks++;
      if (got !== STD_PT) begin
         n_errors++;
         $display("FAIL std_pt: got %b want %b", got, STD_PT);
      end
      n_checks++;
      if (dut.k1_r !== 8'b10100100 || dut.k2_r !== 8'b01000011) begin
         n_errors++;
         $display("FAIL std_subkeys: got K1=%b K2=%b want 10100100 01000011", dut.k1_r, dut.k2_r);
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL std_idle_again: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      int lat, el;
      logic [7:0] got;
      out_ready = 1'b0;
      run_block(STD_KEY, STD_CT, lat, el, got);
      n_checks++;
      if (lat != el || got !== STD_PT) begin
         n_errors++;
         $display("FAIL bp_first: got lat=%0d pt=%b want lat=%0d pt=%b", lat, got, el, STD_PT);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || pt !== STD_PT || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_hold: cycle %0d got out_valid=%b pt=%b in_ready=%b want 1 %b 0", i, out_valid, pt, in_ready, STD_PT);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || pt !== STD_PT) begin
         n_errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b pt=%b want 0 1 %b", out_valid, in_ready, pt, STD_PT);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_single: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int accepts, outs, hs_cyc;
      int acc_cyc [2];
      bit acc_now;
      accepts = 0;
      outs = 0;
      hs_cyc = 0;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      out_ready = 1'b1;
      key = STD_KEY;
      ct = STD_CT;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         acc_now = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc_now) begin
            if (accepts < 2) acc_cyc[accepts] = cyc;
            accepts++;
            if (accepts == 2) in_valid = 1'b0;
         end
         if (out_valid) begin
            outs++;
            if (outs == 1) hs_cyc = cyc;
            n_checks++;
            if (pt !== STD_PT) begin
               n_errors++;
               $display("FAIL b2b_pt: output %0d got %b want %b", outs, pt, STD_PT);
            end
         end
      end
      cache_vld = 1'b1;
      cache_key = STD_KEY;
      n_checks++;
      if (accepts != 2 || outs != 2) begin
         n_errors++;
         $display("FAIL b2b_count: got accepts=%0d outputs=%0d want 2 2", accepts, outs);
      end
      n_checks++;
      if (acc_cyc[1] < hs_cyc + 2) begin
         n_errors++;
         $display("FAIL b2b_order: second accept cycle %0d, first output cycle %0d want accept >= output+2", acc_cyc[1], hs_cyc);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      key = 10'b0111111101;
      ct = 8'h5A;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (dut.state_r !== R1) begin
         n_errors++;
         $display("FAIL mid_in_r1: got state %0d want %0d", dut.state_r, R1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || pt !== 8'd0 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_async: out_valid=%b pt=%b in_ready=%b want 0 00000000 0", out_valid, pt, in_ready);
      end
      #3;
      rst_n = 1'b1;
      cache_vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_no_output: cycle %0d out_valid=%b want 0", i, out_valid);
         end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_ready: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_round_trip();
      int lat, el;
      logic [7:0] got, exp_pt, c;
      logic [9:0] k;
      out_ready = 1'b1;
      for (int ki = 0; ki < 16; ki++) begin
         k = 10'($urandom_range(0, 1023));
         for (int ci = 0; ci < 16; ci++) begin
            c = 8'($urandom_range(0, 255));
            exp_pt = m_decrypt(k, c);
            run_block(k, c, lat, el, got);
            n_checks++;
            if (got !== exp_pt || lat != el) begin
               n_errors++;
               $display("FAIL round_trip: key=%b ct=%b got pt=%b lat=%0d want pt=%b lat=%0d", k, c, got, lat, exp_pt, el);
            end
         end
      end
   endtask

   task automatic test_key_cache();
      int lat, el;
      logic [7:0] got;
      int exp_l [3];
      logic [9:0] keys [3];
      logic [7:0] cts [3];
`ifdef SDES_KEY_CACHE_EN
      exp_l = '{3, 2, 3};
`else
      exp_l = '{3, 3, 3};
`endif
      keys = '{STD_KEY, STD_KEY, 10'b0111111101};
      cts  = '{STD_CT, 8'hC3, 8'h6E};
      rst_n = 1'b0;
      #7;
      rst_n = 1'b1;
      cache_vld = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_block(keys[i], cts[i], lat, el, got);
         n_checks++;
         if (lat != exp_l[i] || got !== m_decrypt(keys[i], cts[i])) begin
            n_errors++;
            $display("FAIL key_cache: block %0d got lat=%0d pt=%b want lat=%0d pt=%b", i, lat, got, exp_l[i], m_decrypt(keys[i], cts[i]));
         end
      end
      n_checks++;
      if (m_decrypt(STD_KEY, STD_CT) !== pt && lat == 3 && i_first_is_std()) begin
         n_errors++;
         $display("FAIL key_cache_pt_hold: got %b", pt);
      end
   endtask

   function automatic bit i_first_is_std();
      return 1'b0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_standard();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_round_trip();
      test_key_cache();
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
